// File: rtl/laser_scorer.sv
// Recounts how many points of a captured 40-point frame fall inside the union of the
// engine's two result circles, flagging engine protocol errors and DONE timeouts.
module laser_scorer #(
    parameter int NPTS    = 40,
    parameter int RADIUS  = 4,
    parameter int TIMEOUT = 65535
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       START,
    input  logic [3:0] X,
    input  logic [3:0] Y,
    input  logic [3:0] C1X,
    input  logic [3:0] C1Y,
    input  logic [3:0] C2X,
    input  logic [3:0] C2Y,
    input  logic       DONE,
    output logic [5:0] SCORE,
    output logic       SCORE_VALID,
    output logic       BUSY,
    output logic       ERR
);

    localparam int IW = $clog2(NPTS);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [IW-1:0] LAST_IDX = IW'(NPTS - 1);
    localparam logic [TW-1:0] LAST_WAIT = TW'(TIMEOUT - 1);
    localparam logic [8:0] R2 = 9'(RADIUS * RADIUS);

    typedef enum logic [2:0] {IDLE, CAPTURE, WAIT_DONE, EVAL, REPORT} state_t;

    state_t        state;
    logic [IW-1:0] idx;
    logic [TW-1:0] timer;
    logic [5:0]    acc;
    logic [3:0]    c1x, c1y, c2x, c2y;
    logic [3:0]    pt_x [NPTS];
    logic [3:0]    pt_y [NPTS];
    logic [3:0]    cur_x, cur_y;
    logic          covered;
    logic          wr_en;
    logic [IW-1:0] wr_idx;

    function automatic logic [8:0] dist2(input logic [3:0] ax, input logic [3:0] ay,
                                         input logic [3:0] bx, input logic [3:0] by);
        logic [3:0] dx;
        logic [3:0] dy;
        logic [7:0] sx;
        logic [7:0] sy;
        dx = (ax >= bx) ? ax - bx : bx - ax;
        dy = (ay >= by) ? ay - by : by - ay;
        sx = {4'b0000, dx} * {4'b0000, dx};
        sy = {4'b0000, dy} * {4'b0000, dy};
        return {1'b0, sx} + {1'b0, sy};
    endfunction

    assign cur_x   = pt_x[idx];
    assign cur_y   = pt_y[idx];
    assign covered = (dist2(cur_x, cur_y, c1x, c1y) <= R2) ||
                     (dist2(cur_x, cur_y, c2x, c2y) <= R2);

    // The point store is deliberately left out of reset; only the control path restarts.
    assign wr_en  = RST_N && (((state == IDLE) && START) || (state == CAPTURE));
    assign wr_idx = (state == IDLE) ? '0 : idx;

    always_ff @(posedge CLK) begin
        if (wr_en) begin
            pt_x[wr_idx] <= X;
            pt_y[wr_idx] <= Y;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state       <= IDLE;
            idx         <= '0;
            timer       <= '0;
            acc         <= '0;
            c1x         <= '0;
            c1y         <= '0;
            c2x         <= '0;
            c2y         <= '0;
            SCORE       <= '0;
            SCORE_VALID <= 1'b0;
            BUSY        <= 1'b0;
            ERR         <= 1'b0;
        end else begin
            SCORE_VALID <= 1'b0;
            ERR         <= 1'b0;
            case (state)
                IDLE: begin
                    if (START) begin
                        idx   <= IW'(1);
                        state <= CAPTURE;
                        BUSY  <= 1'b1;
                    end
                end
                CAPTURE: begin
                    if (DONE) begin
                        ERR   <= 1'b1;
                        BUSY  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        if (idx == LAST_IDX) begin
                            timer <= '0;
                            state <= WAIT_DONE;
                        end
                        idx <= idx + 1'b1;
                    end
                end
                // DONE is tested first so that it beats a timeout landing in the same cycle.
                WAIT_DONE: begin
                    if (DONE) begin
                        c1x   <= C1X;
                        c1y   <= C1Y;
                        c2x   <= C2X;
                        c2y   <= C2Y;
                        idx   <= '0;
                        acc   <= '0;
                        state <= EVAL;
                    end else if (timer == LAST_WAIT) begin
                        ERR   <= 1'b1;
                        BUSY  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                EVAL: begin
                    if (idx == LAST_IDX) begin
                        SCORE       <= acc + {5'b00000, covered};
                        SCORE_VALID <= 1'b1;
                        state       <= REPORT;
                    end else begin
                        acc <= acc + {5'b00000, covered};
                        idx <= idx + 1'b1;
                    end
                end
                REPORT: begin
                    BUSY  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    BUSY  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_laser_scorer.sv
// Randomized bench for laser_scorer: each frame plan is turned into an expected
// per-cycle timeline of BUSY/ERR/SCORE_VALID/SCORE that is compared every cycle.
module tb_laser_scorer;

    localparam int MAXC      = 10000;
    localparam int K_NORMAL  = 0;
    localparam int K_EARLY   = 1;
    localparam int K_TIMEOUT = 2;
    localparam int K_RESET   = 3;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [3:0] x, y, c1x, c1y, c2x, c2y;
    logic       done;
    logic [5:0] score;
    logic       score_valid;
    logic       busy;
    logic       err;

    int cyc = 0;
    int checks = 0;
    int errors = 0;
    bit exp_busy [MAXC];
    bit exp_err [MAXC];
    bit exp_sv [MAXC];
    int exp_score [MAXC];
    int pts_x [40];
    int pts_y [40];
    int cen [4];

    laser_scorer #(.TIMEOUT(10)) dut (
        .CLK(clk), .RST_N(rst_n), .START(start), .X(x), .Y(y),
        .C1X(c1x), .C1Y(c1y), .C2X(c2x), .C2Y(c2y), .DONE(done),
        .SCORE(score), .SCORE_VALID(score_valid), .BUSY(busy), .ERR(err)
    );

    always #5 clk = ~clk;

    task automatic cmp(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("[TB] FAIL %s cyc=%0d got=%0d exp=%0d", name, cyc, act, expv);
        end
    endtask

    task automatic checkOutput();
        cmp("busy", int'(busy), int'(exp_busy[cyc]));
        cmp("err", int'(err), int'(exp_err[cyc]));
        cmp("score_valid", int'(score_valid), int'(exp_sv[cyc]));
        cmp("score", int'(score), exp_score[cyc]);
    endtask

    always @(negedge clk) begin
        if (cyc >= 1 && cyc < MAXC) checkOutput();
    end

    // Coverage count straight from the geometric rule: inside either circle, boundary inclusive.
    function automatic int model_score();
        int n = 0;
        for (int i = 0; i < 40; i++) begin
            int d1 = (pts_x[i] - cen[0]) * (pts_x[i] - cen[0]) + (pts_y[i] - cen[1]) * (pts_y[i] - cen[1]);
            int d2 = (pts_x[i] - cen[2]) * (pts_x[i] - cen[2]) + (pts_y[i] - cen[3]) * (pts_y[i] - cen[3]);
            if (d1 <= 16 || d2 <= 16) n++;
        end
        return n;
    endfunction

    task automatic mark_busy(input int a, input int b);
        for (int i = a; i <= b; i++) if (i < MAXC) exp_busy[i] = 1'b1;
    endtask

    task automatic hold_score(input int t, input int v);
        for (int i = t; i < MAXC; i++) exp_score[i] = v;
    endtask

    task automatic tick();
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic junk(input bit noise);
        x   = 4'($urandom);
        y   = 4'($urandom);
        c1x = 4'($urandom);
        c1y = 4'($urandom);
        c2x = 4'($urandom);
        c2y = 4'($urandom);
        start = noise && ($urandom_range(0, 4) == 0);
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            junk(1'b0);
            done = 1'($urandom);
            tick();
        end
        done = 1'b0;
    endtask

    // Drives one frame; the whole expected timeline is written before the first edge.
    task automatic applyStimulus(input int kind, input int arg, input int wait_cycles, input bit noise);
        int s, d, sc;
        s  = cyc;
        d  = s + 40 + wait_cycles;
        sc = model_score();
        case (kind)
            K_NORMAL: begin
                mark_busy(s + 1, d + 41);
                exp_sv[d + 41] = 1'b1;
                hold_score(d + 41, sc);
            end
            K_EARLY: begin
                mark_busy(s + 1, s + arg);
                exp_err[s + arg + 1] = 1'b1;
            end
            K_TIMEOUT: begin
                mark_busy(s + 1, s + 49);
                exp_err[s + 50] = 1'b1;
            end
            default: begin
                mark_busy(s + 1, d + arg);
                hold_score(d + arg + 1, 0);
            end
        endcase
        for (int i = 0; i < 40; i++) begin
            junk(noise);
            if (i == 0) start = 1'b1;
            x    = 4'(pts_x[i]);
            y    = 4'(pts_y[i]);
            done = (kind == K_EARLY) && (i == arg);
            tick();
            if (kind == K_EARLY && i == arg) begin
                done  = 1'b0;
                start = 1'b0;
                return;
            end
        end
        done = 1'b0;
        if (kind == K_TIMEOUT) begin
            for (int i = 0; i < 10; i++) begin
                junk(noise);
                tick();
            end
            start = 1'b0;
            return;
        end
        for (int i = 0; i < wait_cycles; i++) begin
            junk(noise);
            tick();
        end
        junk(noise);
        c1x  = 4'(cen[0]);
        c1y  = 4'(cen[1]);
        c2x  = 4'(cen[2]);
        c2y  = 4'(cen[3]);
        done = 1'b1;
        tick();
        if (kind == K_RESET) begin
            while (cyc < d + arg) begin
                junk(noise);
                done = noise && ($urandom_range(0, 3) == 0);
                tick();
            end
            junk(1'b0);
            done  = 1'b0;
            rst_n = 1'b0;
            tick();
            rst_n = 1'b1;
        end else begin
            while (cyc < d + 42) begin
                junk(noise);
                done = noise && ($urandom_range(0, 3) == 0);
                tick();
            end
        end
        start = 1'b0;
        done  = 1'b0;
    endtask

    task automatic set_all(input int px, input int py);
        for (int i = 0; i < 40; i++) begin
            pts_x[i] = px;
            pts_y[i] = py;
        end
    endtask

    // Points clustered around the centres so scores spread over the whole range.
    task automatic random_frame();
        for (int k = 0; k < 4; k++) cen[k] = $urandom_range(0, 15);
        for (int i = 0; i < 40; i++) begin
            int sel = $urandom_range(0, 2);
            int bx = (sel == 0) ? cen[0] : (sel == 1) ? cen[2] : $urandom_range(0, 15);
            int by = (sel == 0) ? cen[1] : (sel == 1) ? cen[3] : $urandom_range(0, 15);
            pts_x[i] = bx + $urandom_range(0, 10) - 5;
            pts_y[i] = by + $urandom_range(0, 10) - 5;
            if (pts_x[i] < 0) pts_x[i] = 0;
            if (pts_x[i] > 15) pts_x[i] = 15;
            if (pts_y[i] < 0) pts_y[i] = 0;
            if (pts_y[i] > 15) pts_y[i] = 15;
        end
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        done  = 1'b0;
        junk(1'b0);
        start = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;

        set_all(8, 8);
        cen = '{8, 8, 0, 0};
        cmp("model_full", model_score(), 40);
        applyStimulus(K_NORMAL, 0, 3, 1'b0);
        idle_cycles(1);

        set_all(15, 15);
        pts_x[0] = 4; pts_y[0] = 0;
        pts_x[1] = 4; pts_y[1] = 1;
        cen = '{0, 0, 0, 0};
        cmp("model_boundary", model_score(), 1);
        applyStimulus(K_NORMAL, 0, 0, 1'b0);

        set_all(2, 2);
        cen = '{0, 0, 4, 4};
        cmp("model_overlap", model_score(), 40);
        applyStimulus(K_NORMAL, 0, 9, 1'b1);

        random_frame();
        applyStimulus(K_EARLY, 20, 0, 1'b0);
        random_frame();
        applyStimulus(K_NORMAL, 0, 2, 1'b1);

        random_frame();
        applyStimulus(K_TIMEOUT, 0, 0, 1'b0);
        idle_cycles(2);

        random_frame();
        applyStimulus(K_RESET, 15, 1, 1'b0);
        set_all(8, 8);
        cen = '{8, 8, 0, 0};
        applyStimulus(K_NORMAL, 0, 4, 1'b0);

        for (int f = 0; f < 25; f++) begin
            int r = $urandom_range(0, 9);
            random_frame();
            if (r < 6)       applyStimulus(K_NORMAL, 0, $urandom_range(0, 9), 1'b1);
            else if (r == 6) applyStimulus(K_EARLY, $urandom_range(1, 39), 0, 1'b1);
            else if (r == 7) applyStimulus(K_TIMEOUT, 0, 0, 1'b1);
            else             applyStimulus(K_RESET, $urandom_range(1, 40), $urandom_range(0, 9), 1'b1);
            idle_cycles($urandom_range(0, 2));
        end

        idle_cycles(3);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/laser_scorer.md
Name: laser_scorer

Overview:
- Result-side companion to the two-circle laser placement engine.
- Snoops the same 40-point X/Y input stream the engine receives.
- Captures the engine's C1/C2 result when DONE asserts, then recounts how many stored points lie inside the union of the two radius-R circles.
- Reports the coverage score. Used in-system to self-check each frame and flag timing errors.

Parameters:
- NPTS, 40, points per frame.
- RADIUS, 4, circle radius; inclusion test is dx^2+dy^2 <= RADIUS^2.
- TIMEOUT, 65535, max cycles in WAIT_DONE before error.

Ports:
- CLK  in  1  clock; all logic on rising edge.
- RST_N  in  1  synchronous active-low reset.
- START  in  1  pulse coincident with point 0 of a frame.
- X  in  4  point x, valid START cycle plus following NPTS-1 cycles.
- Y  in  4  point y, same timing as X.
- C1X  in  4  circle 1 centre x from engine.
- C1Y  in  4  circle 1 centre y.
- C2X  in  4  circle 2 centre x.
- C2Y  in  4  circle 2 centre y.
- DONE  in  1  engine result valid (single-cycle pulse).
- SCORE  out  6  covered-point count, 0..NPTS.
- SCORE_VALID  out  1  one-cycle pulse, SCORE valid.
- BUSY  out  1  high in any state other than IDLE.
- ERR  out  1  one-cycle pulse on protocol error or timeout.

Behaviour:
- Reset, synchronous on RST_N=0 at a CLK edge:
  - State goes to IDLE from any state, mid-frame included; the partial frame is discarded.
  - SCORE=0, SCORE_VALID=0, BUSY=0, ERR=0.
  - All counters clear. The point buffer is not cleared.
- States: IDLE, CAPTURE, WAIT_DONE, EVAL, REPORT.
- IDLE:
  - START=1 writes X/Y into buffer[0], sets idx=1 and moves to CAPTURE.
  - DONE in IDLE is ignored.
- CAPTURE:
  - Writes X/Y into buffer[idx] each cycle and increments idx.
  - After the write of buffer[NPTS-1], moves to WAIT_DONE.
  - START is ignored.
  - DONE=1 in CAPTURE: ERR pulses next cycle, state goes to IDLE, no score.
- WAIT_DONE:
  - Timeout counter increments each cycle.
  - DONE=1 latches C1X/C1Y/C2X/C2Y into internal registers, clears idx and the accumulator, and moves to EVAL.
  - Counter reaching TIMEOUT without DONE: ERR pulses, state goes to IDLE.
  - DONE and timeout in the same cycle: DONE wins.
- EVAL:
  - One point per cycle; takes exactly NPTS cycles.
  - For each circle, dx and dy are unsigned absolute differences (4 bit), squared to 8 bit and summed to 9 bit.
  - A point is covered if either sum <= RADIUS^2. The boundary is inclusive.
  - A point covered by both circles counts once. Duplicate points each count.
  - The accumulator is 6 bit and cannot exceed NPTS.
  - Uses the latched centres; the C*X/C*Y inputs may change freely after DONE.
- REPORT:
  - SCORE holds the final count, SCORE_VALID=1 for exactly one cycle, then state goes to IDLE.
  - SCORE keeps its value until the next REPORT or reset.
- Latency: SCORE_VALID asserts NPTS+1 cycles after the DONE cycle (NPTS EVAL cycles plus the REPORT transition).
- START in WAIT_DONE, EVAL or REPORT is ignored; the frame is lost. No back-pressure exists.
- Back-to-back frames: START is accepted on the cycle state is IDLE, including the cycle right after REPORT.
- ERR and SCORE_VALID are never high in the same cycle.

Test Plan:
- All 40 points at (8,8), DONE with C1=(8,8), C2=(0,0) -> SCORE=40, SCORE_VALID one cycle, 41 cycles after DONE.
- Boundary frame: point0=(4,0), point1=(4,1), others (15,15); C1=C2=(0,0) -> SCORE=1, since 16<=16 counts and 17 does not.
- Overlap: 40 points at (2,2), C1=(0,0), C2=(4,4) -> SCORE=40, not 80.
- DONE pulsed at capture index 20 -> ERR one cycle, no SCORE_VALID, BUSY drops, next START accepted.
- TIMEOUT=10 override, no DONE after capture -> ERR on the 10th WAIT_DONE cycle, state IDLE.
- RST_N=0 for one cycle mid-EVAL -> BUSY=0, SCORE=0, SCORE_VALID never pulses. The following full frame scores correctly.
